// File: rtl/dmem_access_unit.sv
// Load/store sequencer between the MEM stage and a valid/ready data memory port.
// Optional macro MISALIGN_TRAP_EN adds misalign_o and suppresses misaligned H/W accesses.
module dmem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_MemRead_i,
  input  logic        MEM_MemWrite_i,
  input  logic [2:0]  MEM_funct3_i,
  input  logic [31:0] MEM_addr_i,
  input  logic [31:0] MEM_wdata_i,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic        mem_req_we_o,
  output logic [31:0] mem_req_addr_o,
  output logic [31:0] mem_req_wdata_o,
  output logic [3:0]  mem_req_be_o,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rsp_rdata_i,
  output logic [31:0] MEM_rdata_o,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign_o,
`endif
  output logic        MEM_stall_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_reg, state_next;
  logic [31:0] addr_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] wdata_reg;
  logic        load_reg;
  logic [31:0] rdata_reg;

  logic        access;
  logic        misalign_hit;
  logic        byte_sz, half_sz, word_sz, sign_ext;
  logic [7:0]  rsp_byte;
  logic [15:0] rsp_half;
  logic [31:0] load_ext;

  assign access = MEM_MemRead_i | MEM_MemWrite_i;

  // Reserved funct3 encodings (x11, 110) fall through to word accesses.
  assign byte_sz  = (funct3_reg[1:0] == 2'b00);
  assign half_sz  = (funct3_reg[1:0] == 2'b01);
  assign word_sz  = funct3_reg[1];
  assign sign_ext = ~funct3_reg[2];

  always_comb begin
    misalign_hit = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (MEM_funct3_i[1:0] == 2'b01)
      misalign_hit = MEM_addr_i[0];
    else if (MEM_funct3_i[1])
      misalign_hit = |MEM_addr_i[1:0];
`endif
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (access) state_next = misalign_hit ? DONE : REQ;
      REQ:  if (mem_req_ready_i) state_next = load_reg ? WAIT : DONE;
      WAIT: if (mem_rsp_valid_i) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields come only from captured registers, so they stay frozen while REQ waits.
  assign mem_req_valid_o = (state_reg == REQ);
  assign mem_req_we_o    = ~load_reg;
  assign mem_req_addr_o  = {addr_reg[31:2], 2'b00};
  assign mem_req_wdata_o = byte_sz ? {4{wdata_reg[7:0]}} :
                           half_sz ? {2{wdata_reg[15:0]}} : wdata_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign mem_req_be_o[gi] = word_sz
                              | (half_sz & (LANE[1] == addr_reg[1]))
                              | (byte_sz & (LANE == addr_reg[1:0]));
    end
  endgenerate

  always_comb begin
    case (addr_reg[1:0])
      2'd0:    rsp_byte = mem_rsp_rdata_i[7:0];
      2'd1:    rsp_byte = mem_rsp_rdata_i[15:8];
      2'd2:    rsp_byte = mem_rsp_rdata_i[23:16];
      default: rsp_byte = mem_rsp_rdata_i[31:24];
    endcase
    rsp_half = addr_reg[1] ? mem_rsp_rdata_i[31:16] : mem_rsp_rdata_i[15:0];
    if (byte_sz)
      load_ext = {{24{sign_ext & rsp_byte[7]}}, rsp_byte};
    else if (half_sz)
      load_ext = {{16{sign_ext & rsp_half[15]}}, rsp_half};
    else
      load_ext = mem_rsp_rdata_i;
  end

  assign MEM_stall_o = ((state_reg == IDLE) & access) | (state_reg == REQ) | (state_reg == WAIT);
  assign MEM_rdata_o = rdata_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      rdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == WAIT) && mem_rsp_valid_i)
        rdata_reg <= load_ext;
    end
  end

  // Capture happens only in IDLE; DONE never re-samples the still-held MEM inputs.
  always_ff @(posedge clk) begin
    if ((state_reg == IDLE) && access) begin
      addr_reg   <= MEM_addr_i;
      funct3_reg <= MEM_funct3_i;
      wdata_reg  <= MEM_wdata_i;
      load_reg   <= MEM_MemRead_i;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_reg;

  always_ff @(posedge clk) begin
    if (!rst_n)
      misalign_reg <= 1'b0;
    else
      misalign_reg <= (state_reg == IDLE) & access & misalign_hit;
  end

  assign misalign_o = misalign_reg;
`endif

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed cases plus randomized loads/stores
// against a byte-level memory reference model; the bench also plays the data memory.
module tb_dmem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        MEM_MemRead_i;
  logic        MEM_MemWrite_i;
  logic [2:0]  MEM_funct3_i;
  logic [31:0] MEM_addr_i;
  logic [31:0] MEM_wdata_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic        mem_req_we_o;
  logic [31:0] mem_req_addr_o;
  logic [31:0] mem_req_wdata_o;
  logic [3:0]  mem_req_be_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_rdata_i;
  logic [31:0] MEM_rdata_o;
  logic        MEM_stall_o;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  dmem_access_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .MEM_MemRead_i   (MEM_MemRead_i),
    .MEM_MemWrite_i  (MEM_MemWrite_i),
    .MEM_funct3_i    (MEM_funct3_i),
    .MEM_addr_i      (MEM_addr_i),
    .MEM_wdata_i     (MEM_wdata_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_we_o    (mem_req_we_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_wdata_o (mem_req_wdata_o),
    .mem_req_be_o    (mem_req_be_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_rdata_i (mem_rsp_rdata_i),
    .MEM_rdata_o     (MEM_rdata_o),
`ifdef MISALIGN_TRAP_EN
    .misalign_o      (misalign_o),
`endif
    .MEM_stall_o     (MEM_stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference memory as bytes; the memory device the DUT talks to is kept as words.
  logic [7:0]  ref_bytes [0:63];
  logic [31:0] mem_words [0:15];
  logic [31:0] exp_rdata;

  logic [3:0]  last_be;
  logic [31:0] last_addr;
  logic [31:0] last_wdata;
  int          last_stall;
  int          last_hs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int w, input logic [31:0] d);
    mem_words[4'(w)] = d;
    for (int b = 0; b < 4; b++)
      ref_bytes[6'(4 * w + b)] = 8'(d >> (8 * b));
  endtask

  task automatic idle(input int n);
    MEM_MemRead_i  = 1'b0;
    MEM_MemWrite_i = 1'b0;
    repeat (n) begin
      mem_rsp_valid_i = 1'($urandom_range(0, 1));
      mem_rsp_rdata_i = $urandom;
      mem_req_ready_i = 1'($urandom_range(0, 1));
      #1;
      check("idle_stall", 32'(MEM_stall_o), 32'd0);
      check("idle_valid", 32'(mem_req_valid_o), 32'd0);
      check("idle_rdata_hold", MEM_rdata_o, exp_rdata);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // One MEM-stage access; the bench answers as memory with rdly ready-low cycles
  // and a response rspdly cycles after acceptance. Called and returns at a negedge.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int rdly, input int rspdly);
    int size, lane, exp_stall, exp_hs;
    int cyc, stall_cnt, hs, waited, rsp_cnt;
    bit is_load, uns, mis, done, pending, seen;
    logic [5:0]  base;
    logic [3:0]  exp_be;
    logic [31:0] exp_wlanes, lane_mask, m, word;
    logic [63:0] v;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    is_load = rd;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    uns  = f3[2] && (size < 4);
    mis  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis  = ((size == 2) && a[0]) || ((size == 4) && (a[1:0] != 2'b00));
`endif
    base = a[5:0] & ~6'(size - 1);
    exp_be = 4'd0;
    exp_wlanes = 32'd0;
    lane_mask = 32'd0;
    for (int k = 0; k < size; k++) begin
      lane = int'(base[1:0]) + k;
      exp_be[2'(lane)] = 1'b1;
      exp_wlanes = exp_wlanes | (32'(8'(wd >> (8 * k))) << (8 * lane));
      lane_mask  = lane_mask | (32'hFF << (8 * lane));
    end
    if (is_load && !mis) begin
      v = 64'd0;
      for (int k = 0; k < size; k++)
        v = v | (64'(ref_bytes[base + 6'(k)]) << (8 * k));
      if ((size < 4) && !uns && v[6'(8 * size - 1)])
        v = v | ~((64'd1 << (8 * size)) - 64'd1);
      exp_rdata = v[31:0];
    end
    exp_stall = mis ? 1 : (is_load ? 2 + rdly + rspdly : 2 + rdly);
    exp_hs    = mis ? 0 : 1;

    MEM_MemRead_i  = rd;
    MEM_MemWrite_i = wr;
    MEM_funct3_i   = f3;
    MEM_addr_i     = a;
    MEM_wdata_i    = wd;

    cyc = 0; stall_cnt = 0; hs = 0; waited = 0; rsp_cnt = 0;
    done = 1'b0; pending = 1'b0; seen = 1'b0;
    cap_addr = 32'd0; cap_wdata = 32'd0; cap_be = 4'd0; cap_we = 1'b0;
    last_be = 4'd0; last_addr = 32'd0; last_wdata = 32'd0;

    while (!done && cyc < 60) begin
      #1;
      if (pending) begin
        if (rsp_cnt == 0) begin
          mem_rsp_valid_i = 1'b1;
          mem_rsp_rdata_i = mem_words[a[5:2]];
          pending = 1'b0;
        end else begin
          mem_rsp_valid_i = 1'b0;
          mem_rsp_rdata_i = $urandom;
          rsp_cnt--;
        end
      end else begin
        mem_rsp_valid_i = 1'($urandom_range(0, 1));
        mem_rsp_rdata_i = $urandom;
      end

      if (!MEM_stall_o) begin
        done = 1'b1;
        check("done_valid", 32'(mem_req_valid_o), 32'd0);
        check("done_rdata", MEM_rdata_o, exp_rdata);
`ifdef MISALIGN_TRAP_EN
        check("done_misalign", 32'(misalign_o), 32'(mis));
`endif
      end else begin
        stall_cnt++;
        if (mem_req_valid_o) begin
          if (!seen) begin
            seen = 1'b1;
            cap_addr = mem_req_addr_o; cap_wdata = mem_req_wdata_o;
            cap_be = mem_req_be_o; cap_we = mem_req_we_o;
            last_be = mem_req_be_o; last_addr = mem_req_addr_o; last_wdata = mem_req_wdata_o;
            check("req_addr", mem_req_addr_o, {a[31:2], 2'b00});
            check("req_we", 32'(mem_req_we_o), 32'(!is_load));
            check("req_be", 32'(mem_req_be_o), 32'(exp_be));
            if (!is_load)
              check("req_wdata", mem_req_wdata_o & lane_mask, exp_wlanes);
          end else begin
            check("stable_addr", mem_req_addr_o, cap_addr);
            check("stable_wdata", mem_req_wdata_o, cap_wdata);
            check("stable_be_we", {27'd0, mem_req_be_o, mem_req_we_o}, {27'd0, cap_be, cap_we});
          end
          if (waited == rdly) begin
            mem_req_ready_i = 1'b1;
            hs++;
            if (!mem_req_we_o) begin
              pending = 1'b1;
              rsp_cnt = rspdly - 1;
            end else begin
              m = 32'd0;
              for (int b = 0; b < 4; b++)
                if (mem_req_be_o[2'(b)]) m = m | (32'hFF << (8 * b));
              word = mem_words[mem_req_addr_o[5:2]];
              mem_words[mem_req_addr_o[5:2]] = (word & ~m) | (mem_req_wdata_o & m);
            end
          end else begin
            mem_req_ready_i = 1'b0;
            waited++;
          end
        end else begin
          mem_req_ready_i = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end

    check("no_timeout", 32'(done), 32'd1);
    check("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
    check("handshakes", 32'(hs), 32'(exp_hs));
    last_stall = stall_cnt;
    last_hs = hs;
    $display("txn rd=%0b wr=%0b f3=%03b addr=%h wdata=%h rdly=%0d rsp=%0d stall=%0d hs=%0d rdata=%h",
             rd, wr, f3, a, wd, rdly, rspdly, stall_cnt, hs, MEM_rdata_o);

    if (!is_load && !mis)
      for (int k = 0; k < size; k++)
        ref_bytes[base + 6'(k)] = 8'(wd >> (8 * k));

    @(posedge clk);
    @(negedge clk);
  endtask

  logic [1:0] rw;

  initial begin
    rst_n = 1'b0;
    MEM_MemRead_i = 1'b0; MEM_MemWrite_i = 1'b0; MEM_funct3_i = 3'd0;
    MEM_addr_i = 32'd0; MEM_wdata_i = 32'd0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_rdata_i = 32'd0;
    exp_rdata = 32'd0;
    last_stall = 0; last_hs = 0;
    for (int w = 0; w < 16; w++) set_word(w, $urandom);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_valid", 32'(mem_req_valid_o), 32'd0);
    check("rst_stall", 32'(MEM_stall_o), 32'd0);
    check("rst_rdata", MEM_rdata_o, 32'd0);
`ifdef MISALIGN_TRAP_EN
    check("rst_misalign", 32'(misalign_o), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    idle(2);

    // LB from 0x103 of word 0x80FF_0000
    set_word(0, 32'h80FF_0000);
    do_access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 0, 1);
    check("lb_be", 32'(last_be), 32'h8);
    check("lb_rdata", MEM_rdata_o, 32'hFFFF_FF80);
    check("lb_stall", 32'(last_stall), 32'd3);

    // SH of 0xABCD to 0x202
    do_access(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 0, 1);
    check("sh_addr", last_addr, 32'h0000_0200);
    check("sh_be", 32'(last_be), 32'hC);
    check("sh_wdata_hi", 32'(last_wdata[31:16]), 32'h0000_ABCD);
    check("sh_stall", 32'(last_stall), 32'd2);

    // LW with ready low for 4 cycles
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'd0, 4, 1);
    check("lw_wait_stall", 32'(last_stall), 32'd7);
    check("lw_wait_hs", 32'(last_hs), 32'd1);

    // LHU from 0x101
    set_word(0, 32'h1234_F00D);
    do_access(1'b1, 1'b0, 3'b101, 32'h0000_0101, 32'd0, 0, 1);
`ifdef MISALIGN_TRAP_EN
    check("lhu_mis_hs", 32'(last_hs), 32'd0);
    check("lhu_mis_stall", 32'(last_stall), 32'd1);
`else
    check("lhu_be", 32'(last_be), 32'h3);
    check("lhu_rdata", MEM_rdata_o, 32'h0000_F00D);
`endif

    // Back-to-back loads
    do_access(1'b1, 1'b0, 3'b100, 32'h0000_0011, 32'd0, 0, 1);
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_0014, 32'd0, 0, 1);
    check("b2b_stall", 32'(last_stall), 32'd3);
    check("b2b_hs", 32'(last_hs), 32'd1);

    // Reset while waiting for a response, then a late response arrives
    set_word(1, 32'hDEAD_BEEF);
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_0004, 32'd0, 0, 1);
    check("pre_rst_rdata", MEM_rdata_o, 32'hDEAD_BEEF);
    MEM_MemRead_i = 1'b1; MEM_MemWrite_i = 1'b0; MEM_funct3_i = 3'b010;
    MEM_addr_i = 32'h0000_0004; mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; MEM_MemRead_i = 1'b0; mem_req_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    mem_rsp_valid_i = 1'b0;
    #1;
    exp_rdata = 32'd0;
    check("wait_rst_stall", 32'(MEM_stall_o), 32'd0);
    check("wait_rst_valid", 32'(mem_req_valid_o), 32'd0);
    check("wait_rst_rdata", MEM_rdata_o, 32'd0);
    @(negedge clk);
    idle(2);

    // Randomized traffic, including both-strobe (load) and reserved funct3
    for (int i = 0; i < 60; i++) begin
      rw = 2'($urandom_range(1, 3));
      do_access(rw[0], rw[1], 3'($urandom), $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
